// File: rtl/gen_regfile.sv
// rtl/gen_regfile.sv - parametrised register file with byte-strobed write, two read ports and a clear engine
module gen_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic               re0,
    input  logic [AW-1:0]      raddr0,
    output logic [WIDTH-1:0]   rdata0,
    output logic               rvalid0,
    input  logic               re1,
    input  logic [AW-1:0]      raddr1,
    output logic [WIDTH-1:0]   rdata1,
    output logic               rvalid1,
    input  logic               clr_req,
    output logic               busy,
    output logic               clr_done
);
    localparam int NB = WIDTH / 8;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                         state_q, state_d;
    logic [AW-1:0]                  ptr_q, ptr_d;
    logic                           busy_q, busy_d;
    logic                           clr_done_q, clr_done_d;
    logic [WIDTH-1:0]               rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                           rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

    logic [DEPTH-1:0][WIDTH-1:0]    ent_all;
    logic [WIDTH-1:0]               wr_old, rd_old0, rd_old1, wr_merged;
    logic                           wr_in_range, wr_acc;

    // Out-of-range addresses match no entry, so reads fall back to zero.
    always_comb begin
        wr_old      = '0;
        rd_old0     = '0;
        rd_old1     = '0;
        wr_in_range = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (waddr == AW'(e)) begin
                wr_old      = ent_all[e];
                wr_in_range = 1'b1;
            end
            if (raddr0 == AW'(e)) rd_old0 = ent_all[e];
            if (raddr1 == AW'(e)) rd_old1 = ent_all[e];
        end
    end

    always_comb begin
        wr_merged = wr_old;
        for (int k = 0; k < NB; k++) begin
            if (wstrb[k]) wr_merged[8*k +: 8] = wdata[8*k +: 8];
        end
    end

    assign wr_acc = (state_q == S_IDLE) && we && wr_in_range;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        logic [WIDTH-1:0] ent_q, ent_d;

        always_comb begin
            ent_d = ent_q;
            if (state_q == S_CLEAR && ptr_q == AW'(e)) begin
                ent_d = '0;
            end else if (wr_acc && waddr == AW'(e)) begin
                ent_d = wr_merged;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ent_q <= '0;
            else        ent_q <= ent_d;
        end

        assign ent_all[e] = ent_q;
    end

    // Write-first bypass: a same-cycle accepted write to the read address wins.
    always_comb begin
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = re0;
        rvalid1_d = re1;
        if (re0) rdata0_d = (wr_acc && raddr0 == waddr) ? wr_merged : rd_old0;
        if (re1) rdata1_d = (wr_acc && raddr1 == waddr) ? wr_merged : rd_old1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        clr_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d    = S_IDLE;
                    ptr_d      = '0;
                    busy_d     = 1'b0;
                    clr_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign busy     = busy_q;
    assign clr_done = clr_done_q;
endmodule

// File: tb/tb_gen_regfile.sv
// tb/tb_gen_regfile.sv - directed bench for gen_regfile at DEPTH=4 and DEPTH=5 against an array model
module tb_gen_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re0, re1, clr_req;
    logic [2:0]  waddr, raddr0, raddr1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic [31:0] r4_0, r4_1, r5_0, r5_1;
    logic        v4_0, v4_1, v5_0, v5_1, busy4, busy5, done4, done5;

    always #5 clk = ~clk;

    gen_regfile #(.WIDTH(32), .DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[1:0]), .wdata(wdata), .wstrb(wstrb),
        .re0(re0), .raddr0(raddr0[1:0]), .rdata0(r4_0), .rvalid0(v4_0),
        .re1(re1), .raddr1(raddr1[1:0]), .rdata1(r4_1), .rvalid1(v4_1),
        .clr_req(clr_req), .busy(busy4), .clr_done(done4)
    );

    gen_regfile #(.WIDTH(32), .DEPTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .re0(re0), .raddr0(raddr0), .rdata0(r5_0), .rvalid0(v5_0),
        .re1(re1), .raddr1(raddr1), .rdata1(r5_1), .rvalid1(v5_1),
        .clr_req(clr_req), .busy(busy5), .clr_done(done5)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Model: index 0 is the DEPTH=4 instance, index 1 the DEPTH=5 instance.
    logic [31:0] mm [2][8];
    int          left [2];
    logic [31:0] ex_rd [2][2];
    logic        ex_rv [2][2];
    logic        ex_busy [2];
    logic        ex_done [2];

    function automatic int dep(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic int ea(input int i, input logic [2:0] a);
        return (i == 0) ? int'(a[1:0]) : int'(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rexp(input int i, input logic [2:0] ra, input int wa, input logic wacc);
        int a;
        a = ea(i, ra);
        if (a >= dep(i)) return 32'h0;
        if (wacc && a == wa) return merge(mm[i][a], wdata, wstrb);
        return mm[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 8; j++) mm[i][j] = 32'h0;
            left[i] = 0;
            ex_busy[i] = 1'b0;
            ex_done[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                ex_rd[i][p] = 32'h0;
                ex_rv[i][p] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        int   d, wa;
        logic wacc;
        for (int i = 0; i < 2; i++) begin
            d    = dep(i);
            wa   = ea(i, waddr);
            wacc = (left[i] == 0) && we && (wa < d);
            if (re0) ex_rd[i][0] = rexp(i, raddr0, wa, wacc);
            if (re1) ex_rd[i][1] = rexp(i, raddr1, wa, wacc);
            ex_rv[i][0] = re0;
            ex_rv[i][1] = re1;
            if (left[i] > 0) begin
                mm[i][d - left[i]] = 32'h0;
                left[i]    = left[i] - 1;
                ex_done[i] = (left[i] == 0);
                ex_busy[i] = (left[i] > 0);
            end else begin
                if (wacc) mm[i][wa] = merge(mm[i][wa], wdata, wstrb);
                ex_done[i] = 1'b0;
                ex_busy[i] = clr_req;
                if (clr_req) left[i] = d;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    endtask

    task automatic compare();
        chk("u4.rdata0",  r4_0,          ex_rd[0][0]);
        chk("u4.rdata1",  r4_1,          ex_rd[0][1]);
        chk("u4.rvalid0", {31'b0, v4_0}, {31'b0, ex_rv[0][0]});
        chk("u4.rvalid1", {31'b0, v4_1}, {31'b0, ex_rv[0][1]});
        chk("u4.busy",    {31'b0, busy4}, {31'b0, ex_busy[0]});
        chk("u4.clr_done",{31'b0, done4}, {31'b0, ex_done[0]});
        chk("u5.rdata0",  r5_0,          ex_rd[1][0]);
        chk("u5.rdata1",  r5_1,          ex_rd[1][1]);
        chk("u5.rvalid0", {31'b0, v5_0}, {31'b0, ex_rv[1][0]});
        chk("u5.rvalid1", {31'b0, v5_1}, {31'b0, ex_rv[1][1]});
        chk("u5.busy",    {31'b0, busy5}, {31'b0, ex_busy[1]});
        chk("u5.clr_done",{31'b0, done5}, {31'b0, ex_done[1]});
    endtask

    task automatic tick();
        if (rst_n) model_step();
        else       model_reset();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        we = 1'b0; re0 = 1'b0; re1 = 1'b0; clr_req = 1'b0;
        waddr = 3'd0; raddr0 = 3'd0; raddr1 = 3'd0; wdata = 32'h0; wstrb = 4'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        idle_inputs();
        we = 1'b1; waddr = a; wdata = d; wstrb = s;
        tick();
    endtask

    task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
        idle_inputs();
        re0 = 1'b1; raddr0 = a0; re1 = 1'b1; raddr1 = a1;
        tick();
    endtask

    int bc, dc;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();

        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 3'(7 - a));
            chk("reset_read_valid", {31'b0, v4_0}, 32'h1);
        end

        wr(3'd2, 32'hDEADBEEF, 4'b1111);
        wr(3'd2, 32'h11223344, 4'b0101);
        rd(3'd2, 3'd0);
        chk("strobe_merge_u4", r4_0, 32'hDE22BE44);
        chk("strobe_merge_u5", r5_0, 32'hDE22BE44);

        idle_inputs();
        we = 1'b1; waddr = 3'd1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        re0 = 1'b1; raddr0 = 3'd1; re1 = 1'b1; raddr1 = 3'd1;
        tick();
        chk("bypass_p0", r4_0, 32'hA5A5A5A5);
        chk("bypass_p1", r4_1, 32'hA5A5A5A5);

        idle_inputs();
        we = 1'b1; waddr = 3'd2; wdata = 32'h00007700; wstrb = 4'b0010;
        re0 = 1'b1; raddr0 = 3'd2;
        tick();
        chk("bypass_partial", r5_0, 32'hDE227744);

        idle_inputs();
        tick();
        chk("hold_rdata", r5_0, 32'hDE227744);
        chk("rvalid_drop", {31'b0, v5_0}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            we = 1'b1; waddr = 3'((i * 3) % 8); wdata = (i * 32'h01010101) ^ 32'hA0B0C0D0; wstrb = 4'(i);
            re0 = 1'b1; raddr0 = 3'(i % 8); re1 = i[0]; raddr1 = 3'((i + 1) % 8);
            tick();
        end

        for (int a = 0; a < 4; a++) wr(3'(a), 32'(a + 1), 4'hF);
        rd(3'd3, 3'd0);
        chk("fill_entry3", r4_0, 32'h4);
        idle_inputs();
        clr_req = 1'b1;
        tick();
        idle_inputs();
        bc = 0; dc = 0;
        while (busy4 && bc < 20) begin
            bc++;
            if (done4) dc++;
            we = 1'b1; waddr = 3'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
            tick();
        end
        if (done4) dc++;
        idle_inputs();
        tick();
        chk("clear_busy_cycles", 32'(bc), 32'd4);
        chk("clear_done_pulses", 32'(dc), 32'd1);
        for (int a = 0; a < 4; a++) begin
            rd(3'(a), 3'(a));
            chk("cleared_entry", r4_0, 32'h0);
        end

        wr(3'd6, 32'h12345678, 4'hF);
        rd(3'd7, 3'd6);
        chk("oob_read_data", r5_0, 32'h0);
        chk("oob_read_valid", {31'b0, v5_0}, 32'h1);
        chk("oob_write_dropped", r5_1, 32'h0);
        for (int a = 0; a < 5; a++) rd(3'(a), 3'(4 - a));

        for (int a = 0; a < 4; a++) wr(3'(a), 32'hC0DE0000 + 32'(a), 4'hF);
        idle_inputs();
        clr_req = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_mid_clear_busy4", {31'b0, busy4}, 32'h0);
        chk("reset_mid_clear_busy5", {31'b0, busy5}, 32'h0);
        dc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done4 || done5) dc++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 || done5) dc++;
        end
        chk("no_done_after_reset", 32'(dc), 32'd0);
        for (int a = 0; a < 5; a++) begin
            rd(3'(a), 3'(a));
            chk("reset_entry_zero", r5_0, 32'h0);
        end

        idle_inputs();
        we = 1'b1; waddr = 3'd3; wdata = 32'h55555555; wstrb = 4'hF; clr_req = 1'b1;
        tick();
        idle_inputs();
        bc = 0;
        while (busy5 && bc < 20) begin
            bc++;
            tick();
        end
        chk("clear_finished", {31'b0, busy5}, 32'h0);
        rd(3'd3, 3'd3);
        chk("write_then_clear", r4_0, 32'h0);
        chk("write_then_clear_u5", r5_1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
